// File: rtl/packer_ctrl_pkg.sv
// rtl/packer_ctrl_pkg.sv - shared widths, state encoding and config check for packer_ctrl
package packer_ctrl_pkg;

    localparam int PKT_WORDS_W  = 12;
    localparam int CHAN_COUNT_W = 3;
    localparam int MAX_CHANS    = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PK_RESET = 3'd1,
        ST_ARM      = 3'd2,
        ST_RUN      = 3'd3,
        ST_STOPPING = 3'd4
    } state_e;

    // A configuration is usable only with 1..MAX_CHANS channels and a non-empty packet.
    function automatic logic cfg_legal(input logic [CHAN_COUNT_W-1:0] chans,
                                       input logic [PKT_WORDS_W-1:0]  words);
        return (chans != '0) && (chans <= CHAN_COUNT_W'(MAX_CHANS)) && (words != '0);
    endfunction

endpackage

// File: rtl/packer_ctrl_framer.sv
// rtl/packer_ctrl_framer.sv - word counter, sop/eop marking, timestamp latch and packet counter
module packer_ctrl_framer
    import packer_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fwd_i,
    input  logic [PKT_WORDS_W-1:0] packet_words_i,
    input  logic [63:0]            data_i,
    input  logic [63:0]            ts_i,
    output logic                   m_valid_o,
    output logic                   m_sop_o,
    output logic                   m_eop_o,
    output logic [63:0]            m_data_o,
    output logic [63:0]            m_timestamp_o,
    output logic [31:0]            pkt_count_o,
    output logic                   eop_accept_o,
    output logic                   pkt_open_o
);

    logic [PKT_WORDS_W-1:0] word_cnt_q, word_cnt_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_sop_q, m_sop_d;
    logic                   m_eop_q, m_eop_d;
    logic [63:0]            m_data_q, m_data_d;
    logic [63:0]            m_ts_q, m_ts_d;
    logic [31:0]            pkt_count_q, pkt_count_d;
    logic                   is_first;
    logic                   is_last;

    // Classify the word being accepted and compute the next framing state.
    always_comb begin
        is_first    = (word_cnt_q == '0);
        is_last     = (word_cnt_q == (packet_words_i - PKT_WORDS_W'(1)));
        m_valid_d   = fwd_i;
        m_sop_d     = fwd_i && is_first;
        m_eop_d     = fwd_i && is_last;
        m_data_d    = fwd_i ? data_i : m_data_q;
        m_ts_d      = (fwd_i && is_first) ? ts_i : m_ts_q;
        word_cnt_d  = word_cnt_q;
        if (fwd_i) begin
            word_cnt_d = is_last ? '0 : word_cnt_q + PKT_WORDS_W'(1);
        end
        pkt_count_d = pkt_count_q + {31'd0, (fwd_i && is_last)};
    end

    // Framing registers; all state is rewritten every cycle from its next value.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_q  <= '0;
            m_valid_q   <= 1'b0;
            m_sop_q     <= 1'b0;
            m_eop_q     <= 1'b0;
            m_data_q    <= '0;
            m_ts_q      <= '0;
            pkt_count_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            m_valid_q   <= m_valid_d;
            m_sop_q     <= m_sop_d;
            m_eop_q     <= m_eop_d;
            m_data_q    <= m_data_d;
            m_ts_q      <= m_ts_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign m_valid_o     = m_valid_q;
    assign m_sop_o       = m_sop_q;
    assign m_eop_o       = m_eop_q;
    assign m_data_o      = m_data_q;
    assign m_timestamp_o = m_ts_q;
    assign pkt_count_o   = pkt_count_q;
    assign eop_accept_o  = fwd_i && is_last;
    assign pkt_open_o    = !is_first;

endmodule

// File: rtl/packer_ctrl.sv
// rtl/packer_ctrl.sv - run/arm/stop sequencing of the sample packer and packet framing
module packer_ctrl
    import packer_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [CHAN_COUNT_W-1:0] cfg_chan_count,
    input  logic [PKT_WORDS_W-1:0]  cfg_packet_words,
    input  logic                    adc_valid,
    output logic                    pk_reset,
    output logic                    pk_en,
    output logic [CHAN_COUNT_W-1:0] pk_enabled_chan_count,
    input  logic                    pk_data_out_valid,
    input  logic                    pk_data_out_sync,
    input  logic [63:0]             pk_data_out,
    input  logic [63:0]             pk_timestamp_out,
    output logic                    m_valid,
    output logic                    m_sop,
    output logic                    m_eop,
    output logic [63:0]             m_data,
    output logic [63:0]             m_timestamp,
    output logic                    busy,
    output logic                    cfg_error,
    output logic [31:0]             pkt_count
);

    state_e                  state_q, state_d;
    logic [CHAN_COUNT_W-1:0] chan_q, chan_d;
    logic [PKT_WORDS_W-1:0]  words_q, words_d;
    logic                    cfg_error_q, cfg_error_d;
    logic                    fwd;
    logic                    eop_accept;
    logic                    pkt_open;

    // A packer word goes downstream once the sync word has been seen, and until the closing eop.
    assign fwd = pk_data_out_valid &&
                 (((state_q == ST_ARM) && run && pk_data_out_sync) ||
                  (state_q == ST_RUN) || (state_q == ST_STOPPING));

    // Next-state and packer control outputs.
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        words_d     = words_q;
        cfg_error_d = cfg_error_q;
        pk_en       = 1'b0;
        pk_reset    = reset;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    if (cfg_legal(cfg_chan_count, cfg_packet_words)) begin
                        chan_d  = cfg_chan_count;
                        words_d = cfg_packet_words;
                        state_d = ST_PK_RESET;
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end
            end
            ST_PK_RESET: begin
                pk_reset = 1'b1;
                state_d  = ST_ARM;
            end
            ST_ARM: begin
                pk_en = adc_valid;
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (fwd) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pk_en = adc_valid;
                if (eop_accept) begin
                    state_d = run ? ST_RUN : ST_IDLE;
                end else if (!run) begin
                    // Nothing open and nothing starting: no packet to close out.
                    state_d = (pkt_open || fwd) ? ST_STOPPING : ST_IDLE;
                end
            end
            ST_STOPPING: begin
                pk_en = adc_valid;
                if (eop_accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) begin
            pk_en = 1'b0;
        end
    end

    // State and latched configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            chan_q      <= CHAN_COUNT_W'(1);
            words_q     <= PKT_WORDS_W'(1);
            cfg_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            words_q     <= words_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    packer_ctrl_framer u_framer (
        .clk            (clk),
        .reset          (reset),
        .fwd_i          (fwd),
        .packet_words_i (words_q),
        .data_i         (pk_data_out),
        .ts_i           (pk_timestamp_out),
        .m_valid_o      (m_valid),
        .m_sop_o        (m_sop),
        .m_eop_o        (m_eop),
        .m_data_o       (m_data),
        .m_timestamp_o  (m_timestamp),
        .pkt_count_o    (pkt_count),
        .eop_accept_o   (eop_accept),
        .pkt_open_o     (pkt_open)
    );

    assign pk_enabled_chan_count = chan_q;
    assign busy                  = (state_q != ST_IDLE);
    assign cfg_error             = cfg_error_q;

endmodule

// File: tb/tb_packer_ctrl.sv
// tb/tb_packer_ctrl.sv - scoreboard bench for packer_ctrl
module tb_packer_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [2:0]  cfg_chan_count = 3'd1;
    logic [11:0] cfg_packet_words = 12'd1;
    logic        adc_valid = 1'b0;
    logic        pk_reset;
    logic        pk_en;
    logic [2:0]  pk_enabled_chan_count;
    logic        pk_data_out_valid = 1'b0;
    logic        pk_data_out_sync = 1'b0;
    logic [63:0] pk_data_out = '0;
    logic [63:0] pk_timestamp_out = '0;
    logic        m_valid, m_sop, m_eop;
    logic [63:0] m_data, m_timestamp;
    logic        busy, cfg_error;
    logic [31:0] pkt_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        sop;
        logic        eop;
        logic [63:0] data;
        logic [63:0] ts;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    packer_ctrl dut (
        .clk                   (clk),
        .reset                 (reset),
        .run                   (run),
        .cfg_chan_count        (cfg_chan_count),
        .cfg_packet_words      (cfg_packet_words),
        .adc_valid             (adc_valid),
        .pk_reset              (pk_reset),
        .pk_en                 (pk_en),
        .pk_enabled_chan_count (pk_enabled_chan_count),
        .pk_data_out_valid     (pk_data_out_valid),
        .pk_data_out_sync      (pk_data_out_sync),
        .pk_data_out           (pk_data_out),
        .pk_timestamp_out      (pk_timestamp_out),
        .m_valid               (m_valid),
        .m_sop                 (m_sop),
        .m_eop                 (m_eop),
        .m_data                (m_data),
        .m_timestamp           (m_timestamp),
        .busy                  (busy),
        .cfg_error             (cfg_error),
        .pkt_count             (pkt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented word must be the next expected one, on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if ((m_sop || m_eop) && !m_valid) begin
            errors++;
            $display("FAIL marker_without_valid sop=%0b eop=%0b valid=%0b required valid=1", m_sop, m_eop, m_valid);
        end
        if (m_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word data=%h required none", m_data);
            end else begin
                e = exp_q.pop_front();
                if (m_sop !== e.sop || m_eop !== e.eop || m_data !== e.data ||
                    m_timestamp !== e.ts || cyc != e.due) begin
                    errors++;
                    $display("FAIL word sop=%0b eop=%0b data=%h ts=%h cyc=%0d required sop=%0b eop=%0b data=%h ts=%h cyc=%0d",
                             m_sop, m_eop, m_data, m_timestamp, cyc, e.sop, e.eop, e.data, e.ts, e.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic word(input logic v, input logic s, input logic [63:0] d, input logic [63:0] t,
                        input logic expect_fwd, input logic sop, input logic eop, input logic [63:0] ets);
        exp_t e;
        pk_data_out_valid = v;
        pk_data_out_sync  = s;
        pk_data_out       = d;
        pk_timestamp_out  = t;
        if (expect_fwd) begin
            e.sop  = sop;
            e.eop  = eop;
            e.data = d;
            e.ts   = ets;
            e.due  = cyc + 1;
            exp_q.push_back(e);
        end
        tick();
        pk_data_out_valid = 1'b0;
        pk_data_out_sync  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while reset is held, with adc_valid high to probe pk_en gating.
        adc_valid = 1'b1;
        tick();
        chk("rst_pk_reset", pk_reset, 1);
        chk("rst_pk_en", pk_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_chan", pk_enabled_chan_count, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_ts", m_timestamp, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_cfg_error", cfg_error, 0);
        tick();
        reset = 1'b0;

        // 4 channels, 3-word packets, continuous adc_valid.
        cfg_chan_count = 3'd4;
        cfg_packet_words = 12'd3;
        run = 1'b1;
        tick();
        chk("s1_pk_reset_pulse", pk_reset, 1);
        chk("s1_chan", pk_enabled_chan_count, 4);
        chk("s1_busy", busy, 1);
        chk("s1_pk_en_in_reset", pk_en, 0);
        tick();
        chk("s1_pk_reset_one_cycle", pk_reset, 0);
        chk("s1_pk_en_arm", pk_en, 1);
        word(1, 1, 64'hD1, 64'hA1, 1, 1, 0, 64'hA1);
        word(1, 0, 64'hD2, 64'hA2, 1, 0, 0, 64'hA1);
        word(1, 1, 64'hD3, 64'hA3, 1, 0, 1, 64'hA1);
        cfg_packet_words = 12'd2;
        cfg_chan_count = 3'd1;
        word(1, 0, 64'hD4, 64'hA4, 1, 1, 0, 64'hA4);
        word(1, 0, 64'hD5, 64'hA5, 1, 0, 0, 64'hA4);
        word(1, 0, 64'hD6, 64'hA6, 1, 0, 1, 64'hA4);
        chk("s1_pkt_count", pkt_count, 2);
        chk("s1_chan_held", pk_enabled_chan_count, 4);
        run = 1'b0;
        tick();
        chk("s1_idle_busy", busy, 0);

        // Illegal configuration.
        do_reset();
        cfg_chan_count = 3'd0;
        cfg_packet_words = 12'd3;
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s2_no_pk_reset", pk_reset, 0);
            chk("s2_busy", busy, 0);
        end
        chk("s2_cfg_error", cfg_error, 1);
        run = 1'b0;
        tick();
        chk("s2_cfg_error_sticky", cfg_error, 1);

        // Words before sync are discarded in ARM.
        do_reset();
        cfg_chan_count = 3'd1;
        cfg_packet_words = 12'd2;
        run = 1'b1;
        tick();
        tick();
        word(1, 0, 64'hE1, 64'hB1, 0, 0, 0, 0);
        word(1, 0, 64'hE2, 64'hB2, 0, 0, 0, 0);
        word(0, 1, 64'hE9, 64'hB9, 0, 0, 0, 0);
        word(1, 1, 64'hE3, 64'hB3, 1, 1, 0, 64'hB3);
        word(1, 0, 64'hE4, 64'hB4, 1, 0, 1, 64'hB3);
        tick();
        chk("s3_pkt_count", pkt_count, 1);
        chk("s3_ts_held", m_timestamp, 64'hB3);
        run = 1'b0;
        tick();
        chk("s3_idle", busy, 0);

        // Run dropped on word 1 of a 4-word packet.
        do_reset();
        cfg_chan_count = 3'd2;
        cfg_packet_words = 12'd4;
        run = 1'b1;
        tick();
        tick();
        word(1, 1, 64'hF0, 64'hC0, 1, 1, 0, 64'hC0);
        run = 1'b0;
        word(1, 0, 64'hF1, 64'hC1, 1, 0, 0, 64'hC0);
        chk("s4_stopping_busy", busy, 1);
        word(1, 0, 64'hF2, 64'hC2, 1, 0, 0, 64'hC0);
        word(1, 0, 64'hF3, 64'hC3, 1, 0, 1, 64'hC0);
        chk("s4_idle_busy", busy, 0);
        chk("s4_idle_pk_en", pk_en, 0);
        chk("s4_pkt_count", pkt_count, 1);
        word(1, 1, 64'hF4, 64'hC4, 0, 0, 0, 0);

        // Reset mid-packet.
        run = 1'b1;
        tick();
        tick();
        word(1, 1, 64'h90, 64'h80, 1, 1, 0, 64'h80);
        word(1, 0, 64'h91, 64'h81, 1, 0, 0, 64'h80);
        reset = 1'b1;
        tick();
        chk("s5_m_valid", m_valid, 0);
        chk("s5_m_sop", m_sop, 0);
        chk("s5_m_eop", m_eop, 0);
        chk("s5_m_data", m_data, 0);
        chk("s5_m_ts", m_timestamp, 0);
        chk("s5_pkt_count", pkt_count, 0);
        chk("s5_busy", busy, 0);
        reset = 1'b0;
        run = 1'b0;
        tick();
        chk("s5_idle_after", busy, 0);

        // Single-word packets and pkt_count wrap.
        do_reset();
        cfg_chan_count = 3'd3;
        cfg_packet_words = 12'd1;
        run = 1'b1;
        tick();
        tick();
        force dut.u_framer.pkt_count_q = 32'hFFFF_FFFE;
        tick();
        release dut.u_framer.pkt_count_q;
        word(1, 1, 64'h70, 64'h60, 1, 1, 1, 64'h60);
        chk("s6_count_max", pkt_count, 32'hFFFF_FFFF);
        word(1, 0, 64'h71, 64'h61, 1, 1, 1, 64'h61);
        chk("s6_count_wrap", pkt_count, 0);
        word(1, 0, 64'h72, 64'h62, 1, 1, 1, 64'h62);
        chk("s6_count_after_wrap", pkt_count, 1);
        run = 1'b0;
        tick();
        chk("s6_idle", busy, 0);

        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_words pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/packer_ctrl.md
PACKER_CTRL -- requirements
Module: packer_ctrl

Interface
REQ-001 SHALL have one clock and one reset: clk input 1, sole clock; reset input 1, synchronous, active-high.
REQ-002 SHALL have run input 1: request streaming; level-sensitive.
REQ-003 SHALL have cfg_chan_count input 3: enabled channels; legal 1..4.
REQ-004 SHALL have cfg_packet_words input 12: words per packet; legal 1..4095.
REQ-005 SHALL have adc_valid input 1: new sample set present on the packer data inputs this cycle.
REQ-006 SHALL have pk_reset output 1: packer reset.
REQ-007 SHALL have pk_en output 1: packer enable.
REQ-008 SHALL have pk_enabled_chan_count output 3: packer channel count.
REQ-009 SHALL have pk_data_out_valid, pk_data_out_sync, pk_data_out[63:0] and pk_timestamp_out[63:0] inputs: packer output.
REQ-010 SHALL have m_valid, m_sop and m_eop outputs (1 bit each), m_data output 64 and m_timestamp output 64: framed stream; no backpressure.
REQ-011 SHALL have busy output 1, cfg_error output 1 (sticky) and pkt_count output 32.

Function
REQ-012 SHALL implement five states: IDLE, PK_RESET, ARM, RUN, STOPPING.
REQ-013 IDLE: pk_en=0, pk_reset=0, busy=0; on run=1 with legal config, latch both cfg_* (pk_enabled_chan_count <= cfg_chan_count) -> PK_RESET.
REQ-014 IDLE with run=1 and illegal config (cfg_chan_count 0 or >4, cfg_packet_words 0): set cfg_error, remain IDLE.
REQ-015 PK_RESET: pk_reset=1 exactly one cycle, pk_en=0 -> ARM.
REQ-016 ARM: pk_en=adc_valid; discard pk words until first pk_data_out_valid with pk_data_out_sync=1; that word starts packet -> RUN.
REQ-017 RUN: pk_en=adc_valid; forward every pk_data_out_valid word; ignore pk_data_out_sync.
REQ-018 Forwarding latency: m_valid/m_data exactly one cycle after pk_data_out_valid/pk_data_out, registered.
REQ-019 m_sop=1 on packet word 0; m_timestamp = pk_timestamp_out of word 0, held stable until next sop.
REQ-020 m_eop=1 on word index latched_packet_words-1; cfg_packet_words=1 gives sop and eop on the same word.
REQ-021 Word counter: 12 bits, clears after eop; pkt_count increments on each eop, wraps 0xFFFFFFFF->0.
REQ-022 run=0 in ARM: -> IDLE immediately (no packet open).
REQ-023 run=0 in RUN: -> STOPPING; keep pk_en=adc_valid until the eop word is emitted, then -> IDLE; a run=0 arriving on the eop cycle goes directly to IDLE.
REQ-024 cfg_* changes outside IDLE: ignored; take effect at the next IDLE->PK_RESET transition.
REQ-025 run re-asserted in STOPPING: ignored until IDLE is reached.
REQ-026 busy=1 in every state except IDLE.
REQ-027 m_sop, m_eop: only ever asserted with m_valid=1.

Reset
REQ-028 reset: state IDLE; pk_reset=1 while reset is high; pk_en=0, pk_enabled_chan_count=1, m_valid/m_sop/m_eop=0, m_data=0, m_timestamp=0, word counter=0, pkt_count=0, cfg_error=0.
REQ-029 Reset mid-packet: packet abandoned, no eop emitted; first cycle after reset behaves as IDLE.

Structure
REQ-030 Package packer_ctrl_pkg SHALL hold the state enum, PKT_WORDS_W=12, CHAN_COUNT_W=3, MAX_CHANS=4.
REQ-031 Framing (word counter, sop/eop, timestamp latch, pkt_count) SHALL be sub-module packer_ctrl_framer; the FSM stays in packer_ctrl.

Verification
REQ-032 Scenario: cfg 4 chans, 3 words, run=1, adc_valid always -> pk_reset one cycle, pk_enabled_chan_count=4, packets of 3 words with sop on word 0, eop on word 2; pkt_count increments per packet.
REQ-033 Scenario: cfg_chan_count=0, run=1 -> cfg_error=1, busy=0, pk_reset never pulses.
REQ-034 Scenario: run dropped on word 1 of a 4-word packet -> words 2,3 emitted, eop on word 3, then IDLE with pk_en=0.
REQ-035 Scenario: in ARM, two pk words with sync=0, then one with sync=1 -> only the sync word and later words appear; m_sop on the sync word; m_timestamp equals its pk_timestamp_out.
REQ-036 Scenario: cfg_packet_words=1 -> every m_valid word has sop=eop=1; pkt_count preset near 0xFFFFFFFF wraps to 0.
REQ-037 Scenario: reset asserted mid-packet -> all m_* outputs 0 next cycle, pkt_count=0, state IDLE.
